core_fetcher: RTL and testbench
===============================

# core_fetcher

Per-core instruction fetch stage sitting directly upstream of the instruction controller: one instance per core, driving one lane of the controller's `fetch_req_*` / `fetch_resp_*` arrays. On the core's FETCH state it issues a val/rdy request for the current PC, accepts the returned instruction and holds it stable for decode. A one-entry last-instruction buffer skips the memory round trip when the same PC is fetched again, e.g. a branch-to-self loop or a stalled re-fetch.

## Interface
Parameters:
- MEM_ADDR_WIDTH, 8, instruction address / PC width
- MEM_DATA_WIDTH, 16, instruction width
- FETCH_STATE, 4'd1, `core_state` encoding that requests a fetch

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- core_state  in  4  current core state
- pc  in  MEM_ADDR_WIDTH  current program counter
- flush  in  1  invalidates the last-instruction buffer
- fetch_req_val  out  1  request valid toward the controller
- fetch_req_rdy  in  1  controller accepts the request
- fetch_req_addr  out  MEM_ADDR_WIDTH  request address
- fetch_resp_val  in  1  controller response valid
- fetch_resp_rdy  out  1  fetcher accepts the response
- fetch_resp_inst  in  MEM_DATA_WIDTH  returned instruction
- inst  out  MEM_DATA_WIDTH  fetched instruction, stable while `inst_val`
- inst_val  out  1  instruction ready for decode
- fetcher_state  out  2  IDLE=0, REQ=1, WAIT=2, DONE=3
- mem_fetch_count  out  16  number of completed memory fetches (saturating)

## Operation
- Registers: `state`, `addr_q`, `inst_q`, `buf_pc`, `buf_inst`, `buf_valid`, `mem_fetch_count`.
- IDLE, with `core_state==FETCH_STATE`:
  - Hit (`buf_valid && pc==buf_pc && !flush`): `inst_q<=buf_inst`, go to DONE.
  - Miss: `addr_q<=pc`, go to REQ.
- IDLE, any other `core_state`: remain in IDLE.
- REQ: `fetch_req_val=1`, `fetch_req_addr=addr_q`. On `fetch_req_rdy` go to WAIT. `addr_q` is held constant until then.
- WAIT: `fetch_resp_rdy=1`. On `fetch_resp_val`:
  - `inst_q<=fetch_resp_inst`
  - `buf_pc<=addr_q`, `buf_inst<=fetch_resp_inst`, `buf_valid<=1`
  - `mem_fetch_count` increments, saturating at 16'hFFFF
  - go to DONE
- DONE: `inst_val=1`, `inst=inst_q`. Go to IDLE when `core_state!=FETCH_STATE`; otherwise stay in DONE. A continued FETCH_STATE does not cause a re-fetch.
- Outputs are Moore, decoded from `state`. `inst` always drives `inst_q`.
- `flush` clears `buf_valid` next cycle in any state.
  - The flush does not abort an in-flight request.
  - If `flush` and a WAIT response capture occur in the same cycle, the capture wins and `buf_valid=1`.
  - `flush` in IDLE in the same cycle as a would-be hit forces a miss.
- A `pc` change after leaving IDLE is ignored until the next IDLE.
- `core_state` leaving FETCH_STATE during REQ or WAIT does not abort. The transaction completes, then DONE exits to IDLE on the following cycle.

## Timing
- Reset asserted (`reset=0`) sets, asynchronously: `state=IDLE`, `fetch_req_val=0`, `fetch_req_addr=0`, `fetch_resp_rdy=0`, `inst=0`, `inst_val=0`, `fetcher_state=0`, `mem_fetch_count=0`, `buf_valid=0`, `buf_pc=0`, `buf_inst=0`.
- Reset asserted mid-transaction drops `fetch_req_val` / `fetch_resp_rdy` immediately. A late response is not accepted.
- Miss latency: FETCH seen in IDLE at cycle 0.
  - `fetch_req_val` is high from cycle 1.
  - With `fetch_req_rdy` at cycle 1 and `fetch_resp_val` at cycle 2, `inst_val` is high at cycle 3. Minimum miss latency is 3 cycles.
  - Each stall cycle on rdy or val adds one cycle.
- Hit latency: `inst_val` is high at cycle 1.
- Handshakes fire on edges where both val and rdy are high.
  - `fetch_req_val` stays asserted until accepted.
  - `fetch_resp_rdy` is high only in WAIT.
  - Exactly one request and one response per miss.

## Test plan
- Basic miss: reset, `pc=8'h10`, FETCH_STATE, controller rdy immediately, response `16'hA5A5` one cycle later -> `fetch_req_addr=8'h10` at cycle 1, `inst=16'hA5A5`, `inst_val` at cycle 3, `mem_fetch_count=1`.
- Back-pressure: `fetch_req_rdy` low for 3 cycles, `fetch_resp_val` delayed 2 cycles -> `fetch_req_val` and `fetch_req_addr` held steady, single handshake each, `inst_val` at cycle 8.
- Buffer hit: after the basic miss, core leaves FETCH then returns with `pc=8'h10` -> no `fetch_req_val`, `inst=16'hA5A5` with `inst_val` one cycle later, count stays 1. Repeat with `pc=8'h11` -> miss issued.
- Flush: after the hit setup, pulse `flush` then FETCH at `pc=8'h10` -> request issued, count 2. Also `flush` coincident with response capture -> next same-PC fetch hits.
- Async reset mid-WAIT: assert `reset=0` in WAIT -> all outputs zero without a clock edge; after release a FETCH at the same PC misses.
- Core leaves FETCH during REQ -> transaction completes, DONE for one cycle, then IDLE. Counter saturation: preload by 65535 misses, or force the counter to 16'hFFFF, then one more miss -> stays 16'hFFFF.

Source files
------------

// File: rtl/core_fetcher.sv
// core_fetcher: per-core instruction fetch stage with a one-entry last-instruction buffer
//   clk, reset (async, active-low)
//   core_state/pc/flush      : core side; FETCH_STATE in IDLE starts a fetch of pc
//   fetch_req_*  / fetch_resp_* : val/rdy request and response lanes toward the controller
//   inst/inst_val            : fetched instruction, held stable while inst_val
//   fetcher_state            : IDLE=0, REQ=1, WAIT=2, DONE=3
//   mem_fetch_count          : completed memory fetches, saturating
module core_fetcher #(
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int MEM_DATA_WIDTH = 16,
  parameter logic [3:0] FETCH_STATE = 4'd1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                core_state,
  input  logic [MEM_ADDR_WIDTH-1:0] pc,
  input  logic                      flush,
  output logic                      fetch_req_val,
  input  logic                      fetch_req_rdy,
  output logic [MEM_ADDR_WIDTH-1:0] fetch_req_addr,
  input  logic                      fetch_resp_val,
  output logic                      fetch_resp_rdy,
  input  logic [MEM_DATA_WIDTH-1:0] fetch_resp_inst,
  output logic [MEM_DATA_WIDTH-1:0] inst,
  output logic                      inst_val,
  output logic [1:0]                fetcher_state,
  output logic [15:0]               mem_fetch_count
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;
  state_t state, state_nxt;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, buf_pc;
  logic [MEM_DATA_WIDTH-1:0] inst_q, buf_inst;
  logic buf_valid, fetch, hit, cap;
  assign fetch = core_state == FETCH_STATE;
  // a flush in the same cycle as the lookup forces a miss
  assign hit = buf_valid && pc == buf_pc && !flush;
  assign cap = state == WAIT && fetch_resp_val;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = fetch ? (hit ? DONE : REQ) : IDLE;
      REQ:  state_nxt = fetch_req_rdy ? WAIT : REQ;
      WAIT: state_nxt = fetch_resp_val ? DONE : WAIT;
      DONE: state_nxt = fetch ? DONE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  assign fetch_req_val  = state == REQ;
  assign fetch_req_addr = addr_q;
  assign fetch_resp_rdy = state == WAIT;
  assign inst_val       = state == DONE;
  assign inst           = inst_q;
  assign fetcher_state  = state;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state           <= IDLE;
      addr_q          <= '0;
      inst_q          <= '0;
      buf_pc          <= '0;
      buf_inst        <= '0;
      buf_valid       <= 1'b0;
      mem_fetch_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && fetch) begin
        if (hit) inst_q <= buf_inst;
        else addr_q <= pc;
      end
      if (cap) begin
        inst_q          <= fetch_resp_inst;
        buf_pc          <= addr_q;
        buf_inst        <= fetch_resp_inst;
        mem_fetch_count <= mem_fetch_count == 16'hFFFF ? mem_fetch_count : mem_fetch_count + 16'd1;
      end
      // a capture in the same cycle as a flush leaves the buffer valid
      buf_valid <= cap || (buf_valid && !flush);
    end
endmodule

// File: tb/tb_core_fetcher.sv
// tb_core_fetcher: table-driven fetch transactions with a scoreboard of expected instructions
module tb_core_fetcher;
  localparam logic [3:0] FETCH = 4'd1;
  logic clk = 0, reset = 0;
  logic [3:0] core_state = 0;
  logic [7:0] pc = 0;
  logic flush = 0, fetch_req_val, fetch_req_rdy = 0, fetch_resp_val = 0, fetch_resp_rdy, inst_val;
  logic [7:0] fetch_req_addr;
  logic [15:0] fetch_resp_inst = 0, inst, mem_fetch_count;
  logic [1:0] fetcher_state;
  int passed = 0, total = 0;
  logic [15:0] exp_q[$];

  core_fetcher #(.MEM_ADDR_WIDTH(8), .MEM_DATA_WIDTH(16), .FETCH_STATE(FETCH)) dut (
    .clk(clk), .reset(reset), .core_state(core_state), .pc(pc), .flush(flush),
    .fetch_req_val(fetch_req_val), .fetch_req_rdy(fetch_req_rdy), .fetch_req_addr(fetch_req_addr),
    .fetch_resp_val(fetch_resp_val), .fetch_resp_rdy(fetch_resp_rdy), .fetch_resp_inst(fetch_resp_inst),
    .inst(inst), .inst_val(inst_val), .fetcher_state(fetcher_state), .mem_fetch_count(mem_fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pc;
    logic        flush_pre, flush_co, flush_resp, leave;
    int          rs, ps;
    logic [15:0] data;
    logic        hit;
    logic [15:0] exp_inst;
    int          lat;
    logic [15:0] cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " req_val"}, {31'd0, fetch_req_val}, 0);
    chk({tag, " req_addr"}, {24'd0, fetch_req_addr}, 0);
    chk({tag, " resp_rdy"}, {31'd0, fetch_resp_rdy}, 0);
    chk({tag, " inst"}, {16'd0, inst}, 0);
    chk({tag, " inst_val"}, {31'd0, inst_val}, 0);
    chk({tag, " state"}, {30'd0, fetcher_state}, 0);
    chk({tag, " count"}, {16'd0, mem_fetch_count}, 0);
  endtask

  // Starts and ends at a negedge with the fetcher in IDLE.
  task automatic run_fetch(input vec_t v);
    int cyc = 0, rs = 0, ps = 0, nreq = 0, nresp = 0;
    bit done = 0;
    logic [15:0] e;
    if (v.flush_pre) begin
      flush = 1;
      @(negedge clk);
      flush = 0;
    end
    exp_q.push_back(v.exp_inst);
    core_state = FETCH;
    pc = v.pc;
    flush = v.flush_co;
    while (!done && cyc < 40) begin
      if (fetch_req_val && fetch_req_rdy) nreq++;
      if (fetch_resp_val && fetch_resp_rdy) nresp++;
      @(negedge clk);
      cyc++;
      flush = 0;
      pc = v.pc ^ 8'hFF;
      if (inst_val) done = 1;
      else begin
        if (v.leave && fetcher_state == 2'd1) core_state = 0;
        if (fetch_req_val) begin
          chk("req_addr", {24'd0, fetch_req_addr}, {24'd0, v.pc});
          fetch_req_rdy = rs >= v.rs;
          rs++;
        end else fetch_req_rdy = 0;
        if (fetch_resp_rdy) begin
          fetch_resp_val = ps >= v.ps;
          fetch_resp_inst = fetch_resp_val ? v.data : 16'hDEAD;
          if (fetch_resp_val) flush = v.flush_resp;
          ps++;
        end else fetch_resp_val = 0;
      end
    end
    fetch_req_rdy = 0;
    fetch_resp_val = 0;
    chk("inst_val_seen", {31'd0, done}, 1);
    chk("latency", cyc, v.lat);
    chk("req_handshakes", nreq, v.hit ? 0 : 1);
    chk("resp_handshakes", nresp, v.hit ? 0 : 1);
    e = exp_q.pop_front();
    chk("inst", {16'd0, inst}, {16'd0, e});
    chk("count", {16'd0, mem_fetch_count}, {16'd0, v.cnt});
    if (v.leave) begin
      @(negedge clk);
      chk("leave_idle", {30'd0, fetcher_state}, 0);
    end else begin
      @(negedge clk);
      chk("done_hold", {30'd0, fetcher_state, fetch_req_val, inst_val}, 32'b1101);
      chk("done_inst", {16'd0, inst}, {16'd0, v.exp_inst});
      core_state = 0;
      @(negedge clk);
      chk("back_idle", {30'd0, fetcher_state}, 0);
    end
  endtask

  vec_t vecs[11];

  initial begin
    //          pc     fpre fco  fres lv   rs ps data      hit  inst      lat cnt
    vecs[0]  = '{8'h10, 0,   0,   0,   0,   0, 0, 16'hA5A5, 0,   16'hA5A5, 3, 16'd1};
    vecs[1]  = '{8'h10, 0,   0,   0,   0,   0, 0, 16'h0000, 1,   16'hA5A5, 1, 16'd1};
    vecs[2]  = '{8'h11, 0,   0,   0,   0,   3, 2, 16'h1234, 0,   16'h1234, 8, 16'd2};
    vecs[3]  = '{8'h11, 0,   0,   0,   0,   0, 0, 16'h0000, 1,   16'h1234, 1, 16'd2};
    vecs[4]  = '{8'h11, 1,   0,   0,   0,   0, 0, 16'h1234, 0,   16'h1234, 3, 16'd3};
    vecs[5]  = '{8'h11, 0,   1,   0,   0,   0, 0, 16'h1234, 0,   16'h1234, 3, 16'd4};
    vecs[6]  = '{8'h11, 0,   0,   0,   0,   0, 0, 16'h0000, 1,   16'h1234, 1, 16'd4};
    vecs[7]  = '{8'h20, 0,   0,   1,   0,   1, 1, 16'h5A5A, 0,   16'h5A5A, 5, 16'd5};
    vecs[8]  = '{8'h20, 0,   0,   0,   0,   0, 0, 16'h0000, 1,   16'h5A5A, 1, 16'd5};
    vecs[9]  = '{8'h30, 0,   0,   0,   1,   1, 0, 16'h0F0F, 0,   16'h0F0F, 4, 16'd6};
    vecs[10] = '{8'h30, 0,   0,   0,   0,   0, 0, 16'h0000, 1,   16'h0F0F, 1, 16'd6};
    #1 chk_idle_outputs("reset");
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    for (int i = 0; i < 11; i++) run_fetch(vecs[i]);
    // async reset while waiting for a response; buffer holds pc 8'h30
    core_state = FETCH;
    pc = 8'h30;
    pc = 8'h40;
    @(negedge clk);
    fetch_req_rdy = fetch_req_val;
    @(negedge clk);
    fetch_req_rdy = 0;
    chk("in_wait", {30'd0, fetcher_state, fetch_resp_rdy}, 32'b101);
    #2 reset = 0;
    #1 chk_idle_outputs("async_reset");
    core_state = 0;
    fetch_resp_val = 1;
    fetch_resp_inst = 16'hBAD0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("late_resp_rdy", {31'd0, fetch_resp_rdy}, 0);
    chk("late_resp_cnt", {16'd0, mem_fetch_count}, 0);
    fetch_resp_val = 0;
    run_fetch('{8'h30, 0, 0, 0, 0, 0, 0, 16'h7777, 0, 16'h7777, 3, 16'd1});
    // saturation
    force dut.mem_fetch_count = 16'hFFFE;
    #1 release dut.mem_fetch_count;
    @(negedge clk);
    run_fetch('{8'h41, 0, 0, 0, 0, 0, 0, 16'h4141, 0, 16'h4141, 3, 16'hFFFF});
    run_fetch('{8'h42, 0, 0, 0, 0, 0, 1, 16'h4242, 0, 16'h4242, 4, 16'hFFFF});
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
